transmit_beam: RTL
==================

TRANSMIT_BEAM -- requirements
Module: transmit_beam

Interface
REQ-001 SHALL have parameter PREP_CYCLES, default 16'd100, giving the Pr_Gate high duration in AD_CLK cycles.
REQ-002 SHALL have parameter HALF_PERIOD, default 4'd5, giving the AD_CLK cycles per pulse half-cycle.
REQ-003 SHALL have parameter PULSE_CYCLES, default 3'd2, giving the full bipolar periods per channel per firing.
REQ-004 SHALL have parameter SAMPLE_LEN, default 16'd15000, giving the sampling window length in AD_CLK cycles.
REQ-005 SHALL have port AD_CLK, in, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port Rst_n, in, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port Start, in, 1: request to fire one line.
REQ-008 SHALL have port Abort, in, 1: synchronous cancel of the current line.
REQ-009 SHALL have port Line_Num, in, 8: line index, 0..255.
REQ-010 SHALL have port Focus_Num, in, 2: focus zone selector.
REQ-011 SHALL have port TX_P, out, 8: positive pulser drive; bit 7 = channel 1, bit 0 = channel 8.
REQ-012 SHALL have port TX_N, out, 8: negative pulser drive, with the same bit mapping as TX_P.
REQ-013 SHALL have ports Pr_Gate, RX_Gate, Sample_Gate and End_Gate, each out, 1: timing gates to the receive beamformer.
REQ-014 SHALL have port Line_Num_Out, out, 8, and port Focus_Num_Out, out, 2: latched copies of the line parameters.
REQ-015 SHALL have port Busy, out, 1, and port Line_Done, out, 1 (a one-cycle pulse).

Function
REQ-016 SHALL implement FSM states IDLE, PREP, FIRE, ARM, SAMPLE and DONE, with Busy=1 in every state except IDLE.
REQ-017 IDLE: Start=1 SHALL latch Line_Num and Focus_Num into the *_Out ports and move the FSM to PREP on the next edge; Start SHALL be ignored while Busy=1.
REQ-018 PREP SHALL hold Pr_Gate=1 for exactly PREP_CYCLES cycles, then move to FIRE.
REQ-019 Per-channel delay D1..D8 in cycles SHALL be 28,24,20,16,12,8,4,0 when latched Focus_Num==2'b10, and 14,12,10,8,6,4,2,0 otherwise. Dmax SHALL be the largest of these values.
REQ-020 FIRE SHALL run counter t=0,1,2,..., where t=0 is the first FIRE cycle. FIRE SHALL last Dmax + 2*HALF_PERIOD*PULSE_CYCLES + 1 cycles, then move to ARM.
REQ-021 Channel k drive window: let u = t - Dk - 1.
  - TX_P[k] SHALL be 1 when 0 <= u < 2*HALF_PERIOD*PULSE_CYCLES and floor(u/HALF_PERIOD) is even.
  - TX_N[k] SHALL be 1 when u is in the same range and floor(u/HALF_PERIOD) is odd.
  - Both SHALL be 0 elsewhere.
REQ-022 TX_P[k] and TX_N[k] SHALL never be 1 in the same cycle, including during Abort and reset.
REQ-023 All outputs SHALL be registered; TX_P and TX_N SHALL be 0 outside FIRE.
REQ-024 ARM SHALL last one cycle, with RX_Gate=1 and Sample_Gate=1 in that cycle, then move to SAMPLE.
REQ-025 SAMPLE SHALL last SAMPLE_LEN cycles, with End_Gate=1 only in the last SAMPLE cycle, then move to DONE.
REQ-026 DONE SHALL last one cycle with Line_Done=1, then move to IDLE; Start may be accepted on the first IDLE cycle.
REQ-027 Abort=1 in any non-IDLE state SHALL force, on the next edge:
  - the FSM to IDLE;
  - all gates and all TX outputs to 0;
  - Line_Done to 0, with no Line_Done pulse for the aborted line.
  Abort in IDLE SHALL have no effect.
REQ-028 Simultaneous Start and Abort in IDLE SHALL leave the FSM in IDLE.
REQ-029 Every counter SHALL be wide enough that it never wraps within its state; PULSE_CYCLES=0 SHALL give a FIRE length of Dmax+1 cycles with no pulses.

Reset
REQ-030 Rst_n=0 SHALL immediately force the following, regardless of AD_CLK:
  - FSM to IDLE and all counters to 0;
  - TX_P, TX_N, Line_Num_Out and Focus_Num_Out to 0;
  - all gates, Busy and Line_Done to 0.
REQ-031 Rst_n deasserted mid-line SHALL leave the block in IDLE, waiting for a new Start, with no spurious pulses.

Verification
REQ-032 Scenario: Start with Focus_Num=2'b00 and Line_Num=8'd37 -> Line_Num_Out=37; Pr_Gate high for 100 cycles; TX_P[0] (channel 8, D=0) high at t=1..5, TX_N[0] at t=6..10, TX_P[0] at t=11..15, TX_N[0] at t=16..20; TX_P[7] (channel 1, D=14) first high at t=15; FIRE lasts 35 cycles.
REQ-033 Scenario: Focus_Num=2'b10 -> channel 1 first TX_P at t=29; FIRE lasts 49 cycles; in ARM, RX_Gate=Sample_Gate=1 for exactly 1 cycle; End_Gate=1 exactly 15000 cycles after ARM; Line_Done=1 for the 1 cycle after End_Gate; Busy=0 the following cycle.
REQ-034 Scenario: Start pulsed during SAMPLE -> ignored; Line_Num_Out unchanged; exactly one Line_Done for the line.
REQ-035 Scenario: Abort at FIRE t=7 -> all TX outputs 0 and FSM in IDLE next cycle; no RX_Gate, End_Gate or Line_Done follows.
REQ-036 Scenario: Rst_n low for 3 cycles mid-PREP -> all outputs 0 asynchronously; after release, Busy=0 until the next Start.
REQ-037 All scenarios SHALL check, on every cycle, that TX_P & TX_N == 8'h00.

Source files
------------

// File: rtl/transmit_beam.sv
// Transmit beam sequencer: prepares the pulser, fires eight delayed bipolar bursts,
// then opens the receive and sample windows for one imaging line.
module transmit_beam #(
    parameter logic [15:0] PREP_CYCLES  = 16'd100,
    parameter logic [3:0]  HALF_PERIOD  = 4'd5,
    parameter logic [2:0]  PULSE_CYCLES = 3'd2,
    parameter logic [15:0] SAMPLE_LEN   = 16'd15000
) (
    input  logic       AD_CLK,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Abort,
    input  logic [7:0] Line_Num,
    input  logic [1:0] Focus_Num,
    output logic [7:0] TX_P,
    output logic [7:0] TX_N,
    output logic       Pr_Gate,
    output logic       RX_Gate,
    output logic       Sample_Gate,
    output logic       End_Gate,
    output logic [7:0] Line_Num_Out,
    output logic [1:0] Focus_Num_Out,
    output logic       Busy,
    output logic       Line_Done
);

    localparam int CntW       = 16;
    localparam int HpVal      = int'(HALF_PERIOD);
    localparam int PcVal      = int'(PULSE_CYCLES);
    localparam int PulseSpan  = 2 * HpVal * PcVal;
    localparam int HpDiv      = (HpVal == 0) ? 1 : HpVal;
    localparam int PrepLast   = (int'(PREP_CYCLES) == 0) ? 0 : int'(PREP_CYCLES) - 1;
    localparam int SampleLast = (int'(SAMPLE_LEN) == 0) ? 0 : int'(SAMPLE_LEN) - 1;

    localparam logic [CntW-1:0] CntOne        = CntW'(1);
    localparam logic [CntW-1:0] PrepLastC     = CntW'(PrepLast);
    localparam logic [CntW-1:0] SampleLastC   = CntW'(SampleLast);
    localparam logic [CntW-1:0] FireLastNearC = CntW'(14 + PulseSpan);
    localparam logic [CntW-1:0] FireLastFarC  = CntW'(28 + PulseSpan);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StFire,
        StArm,
        StSample,
        StDone
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            far_focus;
    logic [CntW-1:0] fire_last;
    logic [7:0]      pat_p;
    logic [7:0]      pat_n;
    int              dly_c;
    int              u_c;
    logic            half_odd;

    assign far_focus = (Focus_Num_Out == 2'b10);
    assign fire_last = far_focus ? FireLastFarC : FireLastNearC;

    // Drive levels for the FIRE cycle after the current one (t_next = cnt_q + 1), so the
    // registered TX outputs line up with the FIRE counter.
    always_comb begin
        pat_p    = '0;
        pat_n    = '0;
        dly_c    = 0;
        u_c      = 0;
        half_odd = 1'b0;
        for (int b = 0; b < 8; b++) begin
            dly_c    = far_focus ? 4 * b : 2 * b;
            u_c      = int'(cnt_q) - dly_c;
            half_odd = ((u_c / HpDiv) % 2) != 0;
            if ((u_c >= 0) && (u_c < PulseSpan)) begin
                pat_p[b] = ~half_odd;
                pat_n[b] = half_odd;
            end
        end
    end

    always_ff @(posedge AD_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            TX_P          <= '0;
            TX_N          <= '0;
            Pr_Gate       <= 1'b0;
            RX_Gate       <= 1'b0;
            Sample_Gate   <= 1'b0;
            End_Gate      <= 1'b0;
            Line_Num_Out  <= '0;
            Focus_Num_Out <= '0;
            Busy          <= 1'b0;
            Line_Done     <= 1'b0;
        end else if (Abort && (state_q != StIdle)) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            TX_P        <= '0;
            TX_N        <= '0;
            Pr_Gate     <= 1'b0;
            RX_Gate     <= 1'b0;
            Sample_Gate <= 1'b0;
            End_Gate    <= 1'b0;
            Busy        <= 1'b0;
            Line_Done   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A Start coinciding with Abort is dropped entirely.
                    if (Start && !Abort) begin
                        Line_Num_Out  <= Line_Num;
                        Focus_Num_Out <= Focus_Num;
                        state_q       <= StPrep;
                        cnt_q         <= '0;
                        Pr_Gate       <= 1'b1;
                        Busy          <= 1'b1;
                    end
                end
                StPrep: begin
                    if (cnt_q == PrepLastC) begin
                        state_q <= StFire;
                        cnt_q   <= '0;
                        Pr_Gate <= 1'b0;
                        TX_P    <= '0;
                        TX_N    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StFire: begin
                    if (cnt_q == fire_last) begin
                        state_q     <= StArm;
                        cnt_q       <= '0;
                        TX_P        <= '0;
                        TX_N        <= '0;
                        RX_Gate     <= 1'b1;
                        Sample_Gate <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                        TX_P  <= pat_p;
                        TX_N  <= pat_n;
                    end
                end
                StArm: begin
                    state_q     <= StSample;
                    cnt_q       <= '0;
                    RX_Gate     <= 1'b0;
                    Sample_Gate <= 1'b0;
                    End_Gate    <= (SampleLastC == '0);
                end
                StSample: begin
                    if (cnt_q == SampleLastC) begin
                        state_q   <= StDone;
                        cnt_q     <= '0;
                        End_Gate  <= 1'b0;
                        Line_Done <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + CntOne;
                        End_Gate <= ((cnt_q + CntOne) == SampleLastC);
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    Line_Done <= 1'b0;
                    Busy      <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
